// File: rtl/vector3_byte_serializer.sv
// Byte serializer for vector3 packer words: streams w, x, y, z (and an optional
// XOR checksum trailer) one byte per valid/ready beat and counts completed frames.
module vector3_byte_serializer #(
  parameter int BYTE_W       = 8,
  parameter int APPEND_CKSUM = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] w,
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic [BYTE_W-1:0] z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  frame_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [2:0] LAST = (APPEND_CKSUM != 0) ? 3'd4 : 3'd3;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_idx;
  logic [BYTE_W-1:0] r_w, r_x, r_y, r_z, r_ck;
  logic [CNT_W-1:0]  r_count;
  logic              w_at_last;
  logic              w_xfer;
  logic              w_last_xfer;
  logic              w_accept;

  assign w_at_last   = (r_state == SEND) && (r_idx == LAST);
  assign out_valid   = (r_state == SEND);
  assign out_last    = w_at_last;
  assign w_xfer      = out_valid && out_ready;
  assign w_last_xfer = w_xfer && w_at_last;
  // Ready on the last beat is combinational from out_ready so frames can run back-to-back.
  assign in_ready    = !areset && ((r_state == IDLE) || (w_at_last && out_ready));
  assign w_accept    = in_valid && in_ready;
  assign frame_count = r_count;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SEND;
      SEND:    if (w_last_xfer && !w_accept) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_idx   <= 3'd0;
      r_w     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_ck    <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_idx <= 3'd0;
        r_w   <= w;
        r_x   <= x;
        r_y   <= y;
        r_z   <= z;
        r_ck  <= w ^ x ^ y ^ z;
      end else if (w_xfer && !w_at_last) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_last_xfer) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    out_data = '0;
    if (r_state == SEND) begin
      case (r_idx)
        3'd0:    out_data = r_w;
        3'd1:    out_data = r_x;
        3'd2:    out_data = r_y;
        3'd3:    out_data = r_z;
        3'd4:    out_data = r_ck;
        default: out_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vector3_byte_serializer.sv
// Directed bench: instance a has the checksum trailer and 16-bit count,
// instance b has no trailer and a 4-bit count to exercise wrap-around.
module tb_vector3_byte_serializer;

  logic       clk = 1'b0;
  logic       areset;
  logic       in_valid_a, in_valid_b;
  logic [7:0] w, x, y, z;
  logic       out_ready;

  logic        in_ready_a, out_valid_a, out_last_a;
  logic [7:0]  out_data_a;
  logic [15:0] fc_a;
  logic        in_ready_b, out_valid_b, out_last_b;
  logic [7:0]  out_data_b;
  logic [3:0]  fc_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vector3_byte_serializer #(.BYTE_W(8), .APPEND_CKSUM(1), .CNT_W(16)) dut_a (
    .clk(clk), .areset(areset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .w(w), .x(x), .y(y), .z(z),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .frame_count(fc_a)
  );

  vector3_byte_serializer #(.BYTE_W(8), .APPEND_CKSUM(0), .CNT_W(4)) dut_b (
    .clk(clk), .areset(areset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .w(w), .x(x), .y(y), .z(z),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .frame_count(fc_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Present a word on the selected instance for one accepting edge.
  task automatic send_word(input bit sel, input logic [7:0] iw, ix, iy, iz);
    w = iw; x = ix; y = iy; z = iz;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(negedge clk);
    chk("in_ready_idle", sel ? in_ready_b : in_ready_a, 1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    w = 8'hDE; x = 8'hAD; y = 8'hBE; z = 8'hEF;
  endtask

  // Check one output cycle, then step to just after the next rising edge.
  task automatic check_beat(input bit sel, input logic [7:0] d, input bit last, input bit rdy);
    @(negedge clk);
    if (sel) begin
      chk("out_valid", out_valid_b, 1);
      chk("out_data", out_data_b, d);
      chk("out_last", out_last_b, last);
      chk("in_ready", in_ready_b, rdy);
    end else begin
      chk("out_valid", out_valid_a, 1);
      chk("out_data", out_data_a, d);
      chk("out_last", out_last_a, last);
      chk("in_ready", in_ready_a, rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_a(input logic [15:0] exp_fc);
    @(negedge clk);
    chk("idle_out_valid", out_valid_a, 0);
    chk("idle_out_data", out_data_a, 0);
    chk("frame_count_a", fc_a, exp_fc);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    w = 8'h00; x = 8'h00; y = 8'h00; z = 8'h00;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_out_last", out_last_a, 0);
    chk("rst_fc", fc_a, 0);
    @(negedge clk); areset = 1'b0;
    @(posedge clk); #1;

    // Basic frame with checksum trailer
    send_word(0, 8'hF8, 8'h3E, 8'h0F, 8'h83);
    check_beat(0, 8'hF8, 0, 0);
    check_beat(0, 8'h3E, 0, 0);
    check_beat(0, 8'h0F, 0, 0);
    check_beat(0, 8'h83, 0, 0);
    check_beat(0, 8'h4A, 1, 1);
    check_idle_a(16'd1);

    // Back-to-back frames with in_valid held high
    w = 8'hF8; x = 8'h3E; y = 8'h0F; z = 8'h83; in_valid_a = 1'b1;
    @(posedge clk); #1;
    w = 8'h00; x = 8'h00; y = 8'h00; z = 8'h07;
    check_beat(0, 8'hF8, 0, 0);
    check_beat(0, 8'h3E, 0, 0);
    check_beat(0, 8'h0F, 0, 0);
    check_beat(0, 8'h83, 0, 0);
    check_beat(0, 8'h4A, 1, 1);
    in_valid_a = 1'b0;
    w = 8'h55; x = 8'h55; y = 8'h55; z = 8'h55;
    check_beat(0, 8'h00, 0, 0);
    check_beat(0, 8'h00, 0, 0);
    check_beat(0, 8'h00, 0, 0);
    check_beat(0, 8'h07, 0, 0);
    check_beat(0, 8'h07, 1, 1);
    check_idle_a(16'd3);

    // Backpressure at idx=2, with in_valid asserted during the stall
    send_word(0, 8'hF8, 8'h3E, 8'h0F, 8'h83);
    check_beat(0, 8'hF8, 0, 0);
    check_beat(0, 8'h3E, 0, 0);
    out_ready = 1'b0;
    in_valid_a = 1'b1; w = 8'h11; x = 8'h22; y = 8'h33; z = 8'h44;
    for (int i = 0; i < 3; i++) check_beat(0, 8'h0F, 0, 0);
    out_ready = 1'b1;
    in_valid_a = 1'b0;
    check_beat(0, 8'h0F, 0, 0);
    check_beat(0, 8'h83, 0, 0);
    check_beat(0, 8'h4A, 1, 1);
    check_idle_a(16'd4);

    // Reset mid-frame at idx=3
    send_word(0, 8'hF8, 8'h3E, 8'h0F, 8'h83);
    check_beat(0, 8'hF8, 0, 0);
    check_beat(0, 8'h3E, 0, 0);
    check_beat(0, 8'h0F, 0, 0);
    areset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid_a, 0);
    chk("abort_out_data", out_data_a, 0);
    chk("abort_out_last", out_last_a, 0);
    chk("abort_in_ready", in_ready_a, 0);
    chk("abort_fc", fc_a, 0);
    @(negedge clk); areset = 1'b0;
    @(posedge clk); #1;
    send_word(0, 8'h00, 8'h00, 8'h00, 8'h07);
    check_beat(0, 8'h00, 0, 0);
    check_beat(0, 8'h00, 0, 0);
    check_beat(0, 8'h00, 0, 0);
    check_beat(0, 8'h07, 0, 0);
    check_beat(0, 8'h07, 1, 1);
    check_idle_a(16'd1);

    // No-trailer instance: all-zero word, 4 beats
    send_word(1, 8'h00, 8'h00, 8'h00, 8'h03);
    check_beat(1, 8'h00, 0, 0);
    check_beat(1, 8'h00, 0, 0);
    check_beat(1, 8'h00, 0, 0);
    check_beat(1, 8'h03, 1, 1);
    @(negedge clk);
    chk("b_idle_valid", out_valid_b, 0);
    chk("b_fc_1", fc_b, 1);
    @(posedge clk); #1;

    // Frames 2..17 on the 4-bit counter: 0xF after 15, 0x0 after 16, 0x1 after 17
    for (int n = 2; n <= 17; n++) begin
      send_word(1, 8'(n), 8'h5A, 8'(n * 3), 8'hC3);
      check_beat(1, 8'(n), 0, 0);
      check_beat(1, 8'h5A, 0, 0);
      check_beat(1, 8'(n * 3), 0, 0);
      check_beat(1, 8'hC3, 1, 1);
      @(negedge clk);
      chk("b_fc_wrap", fc_b, 32'(n % 16));
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vector3_byte_serializer.md
Name: vector3_byte_serializer

Overview:
- Downstream consumer of the vector3 packer, which emits four bytes w, x, y, z formed from {a,b,c,d,e,f,2'b11}.
- Accepts one packed word per valid/ready handshake and streams it out one byte per beat, in the order w, x, y, z.
- When enabled, appends an XOR checksum byte as a trailer.
- Counts completed frames for debug and status readout.

Parameters:
- BYTE_W, 8, width of each byte lane and of out_data.
- APPEND_CKSUM, 1, 1 = send trailer byte w^x^y^z after z; 0 = frame is 4 beats.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word w/x/y/z valid.
- in_ready  out  1  block can accept a word this cycle.
- w  in  BYTE_W  byte 0 (first beat).
- x  in  BYTE_W  byte 1.
- y  in  BYTE_W  byte 2.
- z  in  BYTE_W  byte 3.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  BYTE_W  current byte.
- out_last  out  1  current beat is the final beat of the frame.
- frame_count  out  CNT_W  number of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset areset is asynchronous and active-high.
- Reset values, forced immediately on areset:
  - state = IDLE, beat index idx = 0.
  - Holding registers (4 bytes plus checksum) = 0.
  - out_valid = 0, out_data = 0, out_last = 0, frame_count = 0.
  - in_ready = 0 while areset is high.
- LAST = 4 if APPEND_CKSUM else 3.
- State IDLE:
  - out_valid = 0; out_data = 0; out_last = 0; in_ready = 1.
  - On in_valid & in_ready: latch w, x, y, z; latch cksum = w^x^y^z; idx <= 0; go to SEND.
- State SEND:
  - out_valid = 1.
  - out_data = byte[idx], where idx 0..3 select w, x, y, z and idx 4 selects cksum.
  - out_last = (idx == LAST).
- Beat transfer occurs on out_valid & out_ready:
  - idx < LAST: idx <= idx + 1.
  - idx == LAST: frame_count <= frame_count + 1. If in_valid is also high, load the new word and set idx <= 0, staying in SEND (back-to-back, no bubble). Otherwise go to IDLE.
- in_ready = (state == IDLE) | (state == SEND & idx == LAST & out_ready). This is a combinational path from out_ready; there is no combinational path from in_valid to out_valid.
- Stall (out_valid & !out_ready): out_data, out_last, idx and the holding registers are all held stable. in_valid is ignored.
- Upstream w/x/y/z may change freely after acceptance; output uses only the latched copy.
- Latency: first byte appears on out_data the cycle after the accepting edge. A frame needs LAST+1 transfer cycles minimum, giving a throughput of one word per LAST+1 cycles with out_ready held high.
- areset mid-frame: the frame is aborted, the remaining bytes are discarded, and frame_count does not increment.
- frame_count wraps from 2^CNT_W-1 to 0 with no saturation.

Test Plan:
1. After areset, a..f = 1F,00,1F,00,1F,00 (w=F8, x=3E, y=0F, z=83), out_ready=1.
   - Required: beats F8, 3E, 0F, 83, 4A on consecutive cycles starting 1 cycle after accept.
   - out_last is high only on 4A; frame_count goes to 1.
2. All-zero inputs (w=00, x=00, y=00, z=03), APPEND_CKSUM=0.
   - Required: 4 beats 00, 00, 00, 03, with out_last on 03.
3. Back-to-back: in_valid held high with words F8/3E/0F/83, then 00/00/00/07 (f=01), out_ready=1.
   - Required: 10 beats with no idle cycle between frames; second checksum = 07.
   - in_ready pulses exactly on each last-beat cycle.
4. Backpressure: drop out_ready for 3 cycles while idx=2 in frame 1.
   - Required: out_data holds 0F and out_last holds 0 during the stall, in_ready = 0, no beat is lost or duplicated.
5. Assert areset while idx=3, then release and send frame 2.
   - Required: outputs go to 0 immediately and frame_count = 0.
   - After release, frame 2 transfers cleanly and frame_count = 1.
6. CNT_W=4: send 17 frames.
   - Required: frame_count reads 0xF after 15 frames, 0x0 after 16, 0x1 after 17.
